// File: rtl/pcs_pkg.sv
// Shared definitions for the 64b/66b receive block-sync path:
// sync-header codes, lock FSM states and descrambler taps.
package pcs_pkg;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   localparam int PCS_DATA_W  = 64;
   localparam int SCR_TAP_A   = 39;
   localparam int SCR_TAP_B   = 58;
   localparam int SCR_STATE_W = SCR_TAP_B;

   typedef enum logic [1:0] {
      ST_HUNT      = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } sync_state_e;

   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
   endfunction

endpackage

// File: rtl/pcs_descrambler_64b.sv
// Self-synchronising x^58+x^39+1 descrambler, 64 bits per enabled word,
// bit 0 being the earliest bit on the line.
module pcs_descrambler_64b
   import pcs_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [PCS_DATA_W-1:0] i_data,
   output logic [PCS_DATA_W-1:0] o_data
);

   logic [SCR_STATE_W-1:0]            state_q, state_d;
   logic [SCR_STATE_W+PCS_DATA_W-1:0] stream;

   // Low 58 bits are the previous scrambled bits, state_q[57] the most recent.
   always_comb begin
      stream = {i_data, state_q};
      o_data = '0;
      for (int i = 0; i < PCS_DATA_W; i++) begin
         o_data[i] = stream[SCR_STATE_W + i]
                   ^ stream[SCR_STATE_W + i - SCR_TAP_A]
                   ^ stream[SCR_STATE_W + i - SCR_TAP_B];
      end
      state_d = i_en ? stream[SCR_STATE_W+PCS_DATA_W-1 -: SCR_STATE_W] : state_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= '0;
      else       state_q <= state_d;
   end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b receive block synchroniser: hunts for sync-header lock, requests
// gearbox bitslips, monitors header errors while locked and descrambles payload.
module pcs_rx_block_sync
   import pcs_pkg::*;
#(
   parameter int P_LOCK_CNT  = 64,
   parameter int P_WIN       = 64,
   parameter int P_ERR_LIMIT = 16,
   parameter int P_SLIP_WAIT = 32,
   parameter int P_DESCRAMBLE = 1
) (
   input  logic        i_pcs_clk,
   input  logic        i_rst,
   input  logic        i_rx_valid,
   input  logic [1:0]  i_rx_header,
   input  logic [63:0] i_rx_data,
   output logic        o_slip,
   output logic        o_data_valid,
   output logic        o_pcs_head,
   output logic [63:0] o_pcs_data,
   output logic        o_block_lock,
   output logic [15:0] o_hdr_err_cnt
);

   localparam int GOOD_W = $clog2(P_LOCK_CNT + 1);
   localparam int WAIT_W = $clog2(P_SLIP_WAIT + 1);
   localparam int WIN_W  = $clog2(P_WIN + 1);
   localparam int ERR_W  = $clog2(P_ERR_LIMIT + 1);

   localparam logic [GOOD_W-1:0] LOCK_CNT_L  = GOOD_W'(P_LOCK_CNT);
   localparam logic [WAIT_W-1:0] WAIT_LAST_L = WAIT_W'(P_SLIP_WAIT - 1);
   localparam logic [WIN_W-1:0]  WIN_L       = WIN_W'(P_WIN);
   localparam logic [ERR_W-1:0]  ERR_LIMIT_L = ERR_W'(P_ERR_LIMIT);

   logic [1:0]        rst_sync_q, rst_sync_d;
   logic              rst_int;

   sync_state_e       state_q, state_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_inc;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d, win_inc;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d, err_inc;
   logic              slip_req;

   logic              hdr_ok;
   logic              word_bad;
   logic [63:0]       descr_data;
   logic [63:0]       payload;

   logic              slip_q, slip_d;
   logic              block_lock_q, block_lock_d;
   logic              data_valid_q, data_valid_d;
   logic              pcs_head_q, pcs_head_d;
   logic [63:0]       pcs_data_q, pcs_data_d;
   logic [15:0]       hdr_err_cnt_q, hdr_err_cnt_d;

   // Assertion reaches rst_int asynchronously; release is delayed two clocks.
   assign rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge i_pcs_clk or posedge i_rst) begin
      if (i_rst) rst_sync_q <= 2'b11;
      else       rst_sync_q <= rst_sync_d;
   end

   assign rst_int  = rst_sync_q[1];
   assign hdr_ok   = hdr_is_valid(i_rx_header);
   assign word_bad = i_rx_valid && !hdr_ok;

   // Runs in every state so the descrambler is already aligned when lock is declared.
   pcs_descrambler_64b u_descrambler (
      .i_clk  (i_pcs_clk),
      .i_rst  (rst_int),
      .i_en   (i_rx_valid),
      .i_data (i_rx_data),
      .o_data (descr_data)
   );

   assign payload = (P_DESCRAMBLE != 0) ? descr_data : i_rx_data;

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge i_pcs_clk or posedge rst_int) begin
      if (rst_int) begin
         state_q    <= ST_HUNT;
         good_cnt_q <= '0;
         wait_cnt_q <= '0;
         win_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         win_cnt_q  <= win_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      wait_cnt_d = wait_cnt_q;
      win_cnt_d  = win_cnt_q;
      err_cnt_d  = err_cnt_q;
      slip_req   = 1'b0;
      good_inc   = good_cnt_q + GOOD_W'(1);
      win_inc    = win_cnt_q + WIN_W'(1);
      err_inc    = hdr_ok ? err_cnt_q : err_cnt_q + ERR_W'(1);

      unique case (state_q)
         ST_HUNT: begin
            if (i_rx_valid) begin
               if (!hdr_ok) begin
                  slip_req   = 1'b1;
                  good_cnt_d = '0;
                  wait_cnt_d = '0;
                  state_d    = ST_SLIP_WAIT;
               end else if (good_inc == LOCK_CNT_L) begin
                  good_cnt_d = '0;
                  win_cnt_d  = '0;
                  err_cnt_d  = '0;
                  state_d    = ST_LOCKED;
               end else begin
                  good_cnt_d = good_inc;
               end
            end
         end

         ST_SLIP_WAIT: begin
            if (wait_cnt_q == WAIT_LAST_L) begin
               wait_cnt_d = '0;
               good_cnt_d = '0;
               state_d    = ST_HUNT;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         ST_LOCKED: begin
            if (i_rx_valid) begin
               // Unlock wins over the window wrap when both land on the same word.
               if (!hdr_ok && (err_inc == ERR_LIMIT_L)) begin
                  slip_req   = 1'b1;
                  win_cnt_d  = '0;
                  err_cnt_d  = '0;
                  wait_cnt_d = '0;
                  state_d    = ST_SLIP_WAIT;
               end else if (win_inc == WIN_L) begin
                  win_cnt_d = '0;
                  err_cnt_d = '0;
               end else begin
                  win_cnt_d = win_inc;
                  err_cnt_d = err_inc;
               end
            end
         end

         default: state_d = ST_HUNT;
      endcase
   end

   always_comb begin
      slip_d        = slip_req;
      block_lock_d  = (state_d == ST_LOCKED);
      data_valid_d  = (state_q == ST_LOCKED) && i_rx_valid && hdr_ok;
      pcs_head_d    = pcs_head_q;
      pcs_data_d    = pcs_data_q;
      hdr_err_cnt_d = hdr_err_cnt_q;

      if (data_valid_d) begin
         pcs_head_d = (i_rx_header == HDR_CTRL);
         pcs_data_d = payload;
      end

      if ((state_q == ST_LOCKED) && word_bad && (hdr_err_cnt_q != 16'hFFFF)) begin
         hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_pcs_clk or posedge rst_int) begin
      if (rst_int) begin
         slip_q        <= 1'b0;
         block_lock_q  <= 1'b0;
         data_valid_q  <= 1'b0;
         pcs_head_q    <= 1'b0;
         pcs_data_q    <= '0;
         hdr_err_cnt_q <= '0;
      end else begin
         slip_q        <= slip_d;
         block_lock_q  <= block_lock_d;
         data_valid_q  <= data_valid_d;
         pcs_head_q    <= pcs_head_d;
         pcs_data_q    <= pcs_data_d;
         hdr_err_cnt_q <= hdr_err_cnt_d;
      end
   end

   assign o_slip        = slip_q;
   assign o_block_lock  = block_lock_q;
   assign o_data_valid  = data_valid_q;
   assign o_pcs_head    = pcs_head_q;
   assign o_pcs_data    = pcs_data_q;
   assign o_hdr_err_cnt = hdr_err_cnt_q;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Directed/random bench for pcs_rx_block_sync against a word-level model of the
// lock rules and a bit-serial x^58+x^39+1 scrambler feeding the line.
module tb_pcs_rx_block_sync;

   localparam int P_LOCK_CNT  = 64;
   localparam int P_WIN       = 64;
   localparam int P_ERR_LIMIT = 16;
   localparam int P_SLIP_WAIT = 32;

   logic        i_pcs_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_rx_valid = 1'b0;
   logic [1:0]  i_rx_header = 2'b00;
   logic [63:0] i_rx_data = '0;
   logic        o_slip;
   logic        o_data_valid;
   logic        o_pcs_head;
   logic [63:0] o_pcs_data;
   logic        o_block_lock;
   logic [15:0] o_hdr_err_cnt;

   pcs_rx_block_sync #(
      .P_LOCK_CNT   (P_LOCK_CNT),
      .P_WIN        (P_WIN),
      .P_ERR_LIMIT  (P_ERR_LIMIT),
      .P_SLIP_WAIT  (P_SLIP_WAIT),
      .P_DESCRAMBLE (1)
   ) dut (
      .i_pcs_clk     (i_pcs_clk),
      .i_rst         (i_rst),
      .i_rx_valid    (i_rx_valid),
      .i_rx_header   (i_rx_header),
      .i_rx_data     (i_rx_data),
      .o_slip        (o_slip),
      .o_data_valid  (o_data_valid),
      .o_pcs_head    (o_pcs_head),
      .o_pcs_data    (o_pcs_data),
      .o_block_lock  (o_block_lock),
      .o_hdr_err_cnt (o_hdr_err_cnt)
   );

   always #5 i_pcs_clk = ~i_pcs_clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the lock rules, one call per clock.
   bit          m_locked;
   int          m_good, m_win, m_err, m_wait_left, m_hdr_err;
   bit          exp_slip, exp_dv, exp_head;
   logic [63:0] exp_data;
   bit          tx_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] good_hdr();
      return ($urandom_range(1, 0) != 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_hdr();
      return ($urandom_range(1, 0) != 0) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] pick_mask(input int n, input int lo);
      logic [63:0] m;
      int cnt;
      int p;
      m = '0;
      cnt = 0;
      while (cnt < n) begin
         p = int'($urandom_range(63, lo));
         if (!m[p]) begin
            m[p] = 1'b1;
            cnt++;
         end
      end
      return m;
   endfunction

   // Line scrambler, seed 0: s(n) = d(n) ^ s(n-39) ^ s(n-58); tx_q[57] is s(n-1).
   function automatic logic [63:0] scramble(input logic [63:0] plain);
      logic [63:0] line;
      bit s;
      line = '0;
      for (int i = 0; i < 64; i++) begin
         s = plain[i] ^ tx_q[58 - 39] ^ tx_q[0];
         line[i] = s;
         tx_q.push_back(s);
         void'(tx_q.pop_front());
      end
      return line;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0;
      m_good = 0;
      m_win = 0;
      m_err = 0;
      m_wait_left = 0;
      m_hdr_err = 0;
      exp_slip = 1'b0;
      exp_dv = 1'b0;
      exp_head = 1'b0;
      exp_data = '0;
      tx_q.delete();
      repeat (58) tx_q.push_back(1'b0);
   endtask

   task automatic model_clock(input bit v, input logic [1:0] h, input logic [63:0] plain);
      bit ok;
      ok = (h == 2'b01) || (h == 2'b10);
      exp_slip = 1'b0;
      exp_dv = 1'b0;
      if (m_wait_left > 0) begin
         m_wait_left--;
      end else if (m_locked) begin
         if (v) begin
            m_win++;
            if (!ok) begin
               m_err++;
               if (m_hdr_err < 65535) m_hdr_err++;
            end
            if (!ok && m_err == P_ERR_LIMIT) begin
               m_locked = 1'b0;
               exp_slip = 1'b1;
               m_wait_left = P_SLIP_WAIT;
               m_win = 0;
               m_err = 0;
            end else if (m_win == P_WIN) begin
               m_win = 0;
               m_err = 0;
            end
            if (ok) begin
               exp_dv = 1'b1;
               exp_head = (h == 2'b10);
               exp_data = plain;
            end
         end
      end else if (v) begin
         if (ok) begin
            m_good++;
            if (m_good == P_LOCK_CNT) begin
               m_locked = 1'b1;
               m_good = 0;
               m_win = 0;
               m_err = 0;
            end
         end else begin
            exp_slip = 1'b1;
            m_good = 0;
            m_wait_left = P_SLIP_WAIT;
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".slip"}, o_slip, exp_slip);
      check({ph, ".lock"}, o_block_lock, m_locked);
      check({ph, ".dv"}, o_data_valid, exp_dv);
      check({ph, ".head"}, o_pcs_head, exp_head);
      check({ph, ".data"}, o_pcs_data, exp_data);
      check({ph, ".errcnt"}, o_hdr_err_cnt, 64'(m_hdr_err));
   endtask

   // One clock: drive a word (or a gap), advance the model, sample 1 time unit after the edge.
   task automatic step(input bit v, input logic [1:0] h, input logic [63:0] plain, input string ph);
      logic [63:0] line;
      line = v ? scramble(plain) : rnd64();
      i_rx_valid = v;
      i_rx_header = h;
      i_rx_data = line;
      @(posedge i_pcs_clk);
      model_clock(v, h, plain);
      #1;
      compare_all(ph);
   endtask

   task automatic apply_reset();
      i_rst = 1'b1;
      #1;
      model_reset();
      check("rst.slip", o_slip, 0);
      check("rst.lock", o_block_lock, 0);
      check("rst.dv", o_data_valid, 0);
      check("rst.head", o_pcs_head, 0);
      check("rst.data", o_pcs_data, 0);
      check("rst.errcnt", o_hdr_err_cnt, 0);
      repeat (2) @(posedge i_pcs_clk);
      #1 i_rst = 1'b0;
      repeat (3) step(1'b0, bad_hdr(), rnd64(), "rst_idle");
   endtask

   initial begin
      logic [63:0] mask;
      logic [63:0] pat;
      logic [1:0]  h;
      int          nbad;

      #2;
      apply_reset();

      // Lock after 64 good headers, then 16 spread errors in the first window unlock.
      for (int w = 0; w < P_LOCK_CNT; w++) begin
         step(1'b1, good_hdr(), rnd64(), "hunt");
         if (w == P_LOCK_CNT - 2) check("lock_before_64", o_block_lock, 0);
      end
      check("lock_after_64", o_block_lock, 1);
      mask = pick_mask(P_ERR_LIMIT, 1);
      nbad = 0;
      for (int w = 0; w < P_WIN && nbad < P_ERR_LIMIT; w++) begin
         if (mask[w]) begin
            nbad++;
            step(1'b1, bad_hdr(), rnd64(), "win16");
         end else begin
            step(1'b1, good_hdr(), rnd64(), "win16");
         end
         if (w == 0) check("dv_word65", o_data_valid, 1);
      end
      check("unlock_slip", o_slip, 1);
      check("unlock_lock", o_block_lock, 0);
      check("unlock_errcnt", o_hdr_err_cnt, 16);
      step(1'b0, good_hdr(), rnd64(), "post_unlock");
      check("unlock_slip_1clk", o_slip, 0);

      // Invalid header at hunting word 10, slip wait ignores input, hunt restarts from zero.
      apply_reset();
      for (int w = 0; w < 10; w++) step(1'b1, good_hdr(), rnd64(), "hunt10");
      step(1'b1, 2'b11, rnd64(), "hunt_bad");
      check("hunt_slip", o_slip, 1);
      for (int c = 0; c < P_SLIP_WAIT; c++) begin
         h = (c == P_SLIP_WAIT - 1 || $urandom_range(1, 0) != 0) ? bad_hdr() : good_hdr();
         step(1'b1, h, rnd64(), "slip_wait");
         check("wait_no_slip", o_slip, 0);
      end
      for (int w = 0; w < P_LOCK_CNT - 1; w++) step(1'b1, good_hdr(), rnd64(), "rehunt");
      check("rehunt_no_lock_63", o_block_lock, 0);
      step(1'b1, good_hdr(), rnd64(), "rehunt");
      check("rehunt_lock_64", o_block_lock, 1);

      // 15 errors per window over 3 windows, with valid gaps, keeps lock.
      apply_reset();
      for (int w = 0; w < P_LOCK_CNT; w++) step(1'b1, good_hdr(), rnd64(), "hunt3");
      for (int win = 0; win < 3; win++) begin
         mask = pick_mask(P_ERR_LIMIT - 1, 0);
         for (int w = 0; w < P_WIN; w++) begin
            if ($urandom_range(3, 0) == 0) step(1'b0, bad_hdr(), rnd64(), "gap15");
            step(1'b1, mask[w] ? bad_hdr() : good_hdr(), rnd64(), "win15");
         end
         check("win15_lock", o_block_lock, 1);
      end
      check("win15_errcnt_45", o_hdr_err_cnt, 45);

      // Counting pattern through the scrambler with gaps; payload must come back intact.
      apply_reset();
      for (int k = 0; k < P_LOCK_CNT + 40; k++) begin
         if ($urandom_range(2, 0) == 0) step(1'b0, bad_hdr(), rnd64(), "pat_gap");
         pat = {~32'(k), 32'(k)};
         h = good_hdr();
         step(1'b1, h, pat, "pat");
         if (k >= P_LOCK_CNT) begin
            check("pat_dv", o_data_valid, 1);
            check("pat_data", o_pcs_data, pat);
            check("pat_head", o_pcs_head, {63'd0, h == 2'b10});
         end
      end

      // Reset while locked and mid-window, then re-lock.
      check("pre_rst_lock", o_block_lock, 1);
      apply_reset();
      for (int w = 0; w < P_LOCK_CNT - 1; w++) step(1'b1, good_hdr(), rnd64(), "relock");
      check("relock_no_lock_63", o_block_lock, 0);
      step(1'b1, good_hdr(), rnd64(), "relock");
      check("relock_lock_64", o_block_lock, 1);
      step(1'b1, good_hdr(), 64'hA5A5_0000_FFFF_1234, "relock_data");
      check("relock_dv", o_data_valid, 1);
      check("relock_data", o_pcs_data, 64'hA5A5_0000_FFFF_1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
